// File: rtl/thrust_input_ctrl.sv
// Player control conditioning for the lunar lander cabinet inputs: thrust lever
// value (analog stick or d-pad ramp) and active-low rotate lines with stick hysteresis.
module thrust_input_ctrl #(
  parameter int unsigned TICK_DIV   = 98425,
  parameter int unsigned THRUST_MAX = 254,
  parameter int unsigned TURN_ON    = 64,
  parameter int unsigned TURN_OFF   = 48
) (
  input  logic       clk_25,
  input  logic       RESET_L,
  input  logic [7:0] analog_y,
  input  logic [7:0] analog_x,
  input  logic       mode_dpad,
  input  logic       dpad_up,
  input  logic       dpad_down,
  input  logic       btn_turn_l,
  input  logic       btn_turn_r,
  output logic [7:0] thrust_out,
  output logic       rot_left_l,
  output logic       rot_right_l,
  output logic       ramp_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW    = 8;
  localparam int unsigned SW    = 9;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [TW-1:0]      TMAX     = TW'(THRUST_MAX);
  localparam logic signed [SW-1:0] POS_ON  = SW'(TURN_ON);
  localparam logic signed [SW-1:0] POS_OFF = SW'(TURN_OFF);
  localparam logic signed [SW-1:0] NEG_ON  = -POS_ON;
  localparam logic signed [SW-1:0] NEG_OFF = -POS_OFF;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [TW-1:0]    acc_q, acc_d;
  logic [TW-1:0]    thrust_q, thrust_d;
  logic             mode_q, mode_d;
  logic             hyst_l_q, hyst_l_d;
  logic             hyst_r_q, hyst_r_d;
  logic             rot_l_q, rot_l_d;
  logic             rot_r_q, rot_r_d;

  logic signed [SW-1:0] tgt9;
  logic signed [SW-1:0] x9;
  logic [TW-1:0]        atgt;
  logic                 want_l;
  logic                 want_r;

  // Next-state logic for prescaler, accumulator, output and rotate paths
  always_comb begin
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    acc_d    = acc_q;
    thrust_d = thrust_q;
    mode_d   = mode_dpad;
    hyst_l_d = hyst_l_q;
    hyst_r_d = hyst_r_q;
    rot_l_d  = rot_l_q;
    rot_r_d  = rot_r_q;

    tick_d = (cnt_q == CNT_LAST);
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

    // 9-bit signed so y=-128 maps to 255 without wrapping
    tgt9 = $signed(SW'(127)) - $signed({analog_y[7], analog_y});
    atgt = ($unsigned(tgt9) > SW'(THRUST_MAX)) ? TMAX : tgt9[TW-1:0];

    // Entering d-pad mode seeds the ramp from the live output; a coincident tick is dropped
    if (mode_dpad && !mode_q) begin
      acc_d = thrust_q;
    end else if (tick_q && mode_q) begin
      if (dpad_up && !dpad_down && (acc_q < TMAX)) begin
        acc_d = acc_q + TW'(1);
      end else if (dpad_down && !dpad_up && (acc_q != '0)) begin
        acc_d = acc_q - TW'(1);
      end
    end

    thrust_d = mode_q ? acc_q : atgt;

    x9 = $signed({analog_x[7], analog_x});
    if (x9 < NEG_ON) begin
      hyst_l_d = 1'b1;
    end else if (x9 > NEG_OFF) begin
      hyst_l_d = 1'b0;
    end
    if (x9 > POS_ON) begin
      hyst_r_d = 1'b1;
    end else if (x9 < POS_OFF) begin
      hyst_r_d = 1'b0;
    end

    // Conflicting requests cancel to no rotation
    want_l  = hyst_l_q | btn_turn_l;
    want_r  = hyst_r_q | btn_turn_r;
    rot_l_d = ~(want_l & ~want_r);
    rot_r_d = ~(want_r & ~want_l);
  end

  always_ff @(posedge clk_25) begin
    if (!RESET_L) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      acc_q    <= '0;
      thrust_q <= '0;
      mode_q   <= 1'b0;
      hyst_l_q <= 1'b0;
      hyst_r_q <= 1'b0;
      rot_l_q  <= 1'b1;
      rot_r_q  <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      acc_q    <= acc_d;
      thrust_q <= thrust_d;
      mode_q   <= mode_d;
      hyst_l_q <= hyst_l_d;
      hyst_r_q <= hyst_r_d;
      rot_l_q  <= rot_l_d;
      rot_r_q  <= rot_r_d;
    end
  end

  assign thrust_out  = thrust_q;
  assign rot_left_l  = rot_l_q;
  assign rot_right_l = rot_r_q;
  assign ramp_tick   = tick_q;

endmodule

// File: tb/tb_thrust_input_ctrl.sv
// Directed bench for thrust_input_ctrl with a short prescaler (TICK_DIV=4).
module tb_thrust_input_ctrl;

  logic       clk_25 = 1'b0;
  logic       RESET_L;
  logic [7:0] analog_y;
  logic [7:0] analog_x;
  logic       mode_dpad;
  logic       dpad_up;
  logic       dpad_down;
  logic       btn_turn_l;
  logic       btn_turn_r;
  logic [7:0] thrust_out;
  logic       rot_left_l;
  logic       rot_right_l;
  logic       ramp_tick;

  int n_cmp = 0;
  int n_err = 0;

  always #20 clk_25 = ~clk_25;

  thrust_input_ctrl #(
    .TICK_DIV  (4),
    .THRUST_MAX(254),
    .TURN_ON   (64),
    .TURN_OFF  (48)
  ) dut (
    .clk_25     (clk_25),
    .RESET_L    (RESET_L),
    .analog_y   (analog_y),
    .analog_x   (analog_x),
    .mode_dpad  (mode_dpad),
    .dpad_up    (dpad_up),
    .dpad_down  (dpad_down),
    .btn_turn_l (btn_turn_l),
    .btn_turn_r (btn_turn_r),
    .thrust_out (thrust_out),
    .rot_left_l (rot_left_l),
    .rot_right_l(rot_right_l),
    .ramp_tick  (ramp_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_25);
    #1;
  endtask

  // Advance until ramp_tick is seen high, at most 8 cycles
  task automatic wait_tick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1);
      seen = ramp_tick;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int exp;
    RESET_L    = 1'b0;
    analog_y   = 8'(-128);
    analog_x   = 8'd0;
    mode_dpad  = 1'b0;
    dpad_up    = 1'b0;
    dpad_down  = 1'b0;
    btn_turn_l = 1'b0;
    btn_turn_r = 1'b0;

    // Analog thrust mapping and reset state
    step(2);
    check("rst_thrust", 32'(thrust_out), 32'd0);
    check("rst_rot_l", 32'(rot_left_l), 32'd1);
    check("rst_rot_r", 32'(rot_right_l), 32'd1);
    check("rst_tick", 32'(ramp_tick), 32'd0);
    RESET_L = 1'b1;
    step(1);
    check("y_m128", 32'(thrust_out), 32'd254);
    analog_y = 8'd0;
    step(1);
    check("y_0", 32'(thrust_out), 32'd127);
    analog_y = 8'd127;
    step(1);
    check("y_127", 32'(thrust_out), 32'd0);
    analog_y = 8'(-1);
    step(1);
    check("y_m1", 32'(thrust_out), 32'd128);

    // D-pad ramp up to the clamp and back down to zero
    RESET_L   = 1'b0;
    mode_dpad = 1'b1;
    analog_y  = 8'd127;
    dpad_up   = 1'b1;
    step(2);
    RESET_L = 1'b1;
    for (int n = 1; n <= 1100; n++) begin
      step(1);
      exp = (n < 2) ? 0 : (n - 2) / 4;
      if (exp > 254) exp = 254;
      check($sformatf("ramp_up_%0d", n), 32'(thrust_out), 32'(exp));
    end
    dpad_up   = 1'b0;
    dpad_down = 1'b1;
    for (int n = 1101; n <= 2200; n++) begin
      step(1);
      exp = (n < 1102) ? 254 : 253 - (n - 1102) / 4;
      if (exp < 0) exp = 0;
      check($sformatf("ramp_dn_%0d", n), 32'(thrust_out), 32'(exp));
    end
    dpad_down = 1'b0;

    // Bumpless analog to d-pad transfer, then a single up step
    mode_dpad = 1'b0;
    analog_y  = 8'(-28);
    step(2);
    check("bump_analog", 32'(thrust_out), 32'd155);
    mode_dpad = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("bump_hold_%0d", i), 32'(thrust_out), 32'd155);
    end
    wait_tick("bump_tick0");
    step(1);
    dpad_up = 1'b1;
    wait_tick("bump_tick1");
    step(1);
    dpad_up = 1'b0;
    step(1);
    check("bump_step", 32'(thrust_out), 32'd156);
    step(6);
    check("bump_stay", 32'(thrust_out), 32'd156);

    // Stick X hysteresis on the left, the -128 corner and the right side
    analog_x = 8'(-10);
    step(3);
    check("x_m10", 32'(rot_left_l), 32'd1);
    analog_x = 8'(-65);
    step(1);
    check("x_m65_lat1", 32'(rot_left_l), 32'd1);
    step(1);
    check("x_m65_lat2", 32'(rot_left_l), 32'd0);
    analog_x = 8'(-50);
    step(3);
    check("x_m50_hold", 32'(rot_left_l), 32'd0);
    analog_x = 8'(-48);
    step(3);
    check("x_m48_hold", 32'(rot_left_l), 32'd0);
    analog_x = 8'(-47);
    step(1);
    check("x_m47_lat1", 32'(rot_left_l), 32'd0);
    step(1);
    check("x_m47_lat2", 32'(rot_left_l), 32'd1);
    analog_x = 8'(-64);
    step(3);
    check("x_m64_off", 32'(rot_left_l), 32'd1);
    analog_x = 8'(-128);
    step(2);
    check("x_m128_l", 32'(rot_left_l), 32'd0);
    check("x_m128_r", 32'(rot_right_l), 32'd1);
    analog_x = 8'd65;
    step(2);
    check("x_p65_r", 32'(rot_right_l), 32'd0);
    check("x_p65_l", 32'(rot_left_l), 32'd1);
    analog_x = 8'd50;
    step(3);
    check("x_p50_hold", 32'(rot_right_l), 32'd0);
    analog_x = 8'd0;
    step(2);
    check("x_0_r", 32'(rot_right_l), 32'd1);

    // Conflicting stick-left and button-right cancel out
    analog_x = 8'(-100);
    step(2);
    check("conf_pre", 32'(rot_left_l), 32'd0);
    btn_turn_r = 1'b1;
    step(1);
    check("conf_l", 32'(rot_left_l), 32'd1);
    check("conf_r", 32'(rot_right_l), 32'd1);
    btn_turn_r = 1'b0;
    step(1);
    check("conf_rel_l", 32'(rot_left_l), 32'd0);
    check("conf_rel_r", 32'(rot_right_l), 32'd1);
    analog_x = 8'd0;
    step(2);
    check("btn_pre", 32'(rot_left_l), 32'd1);
    btn_turn_l = 1'b1;
    step(1);
    check("btn_l", 32'(rot_left_l), 32'd0);

    // Reset mid-ramp discards the accumulator and restarts the prescaler
    analog_y = 8'd127;
    dpad_up  = 1'b1;
    step(3);
    RESET_L = 1'b0;
    step(1);
    check("mid_rst_thrust", 32'(thrust_out), 32'd0);
    check("mid_rst_rot_l", 32'(rot_left_l), 32'd1);
    check("mid_rst_rot_r", 32'(rot_right_l), 32'd1);
    check("mid_rst_tick", 32'(ramp_tick), 32'd0);
    RESET_L = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step(1);
      check($sformatf("rel_tick_%0d", n), 32'(ramp_tick), (n == 4) ? 32'd1 : 32'd0);
    end
    step(1);
    check("rel_thrust", 32'(thrust_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
